spi_config_memory_arbiter: RTL and testbench
============================================

Name: spi_config_memory_arbiter

Overview:
- Sequences configuration SRAM accesses requested by the SPI clock-crossing stage and shares the single-port SRAM with the core datapath.
- Consumes the one-cycle write pulse and the synchronized read level from the barrier crossing, and turns them into SRAM write and read cycles.
- Returns SPI read data in the clk domain.
- Arbitrates against a core request/grant port; SPI traffic has priority while configuration is enabled.

Parameters:
- ADDR_WIDTH, 10, SRAM word-address width.
- DATA_WIDTH, 32, SRAM word width.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset (rst=0 resets on the clock edge).
- enable_configuration  input  1  SPI path allowed to access the SRAM.
- write_new  input  1  one-cycle pulse: SPI write word ready.
- read_sync  input  1  synchronized SPI read-request level; rising edge = request.
- spi_addr  input  ADDR_WIDTH  SPI target address, stable around the write_new pulse and the read_sync edge.
- spi_wdata  input  DATA_WIDTH  SPI write data.
- spi_rdata  output  DATA_WIDTH  last SPI read result (held).
- spi_rdata_valid  output  1  one-cycle pulse: spi_rdata updated.
- spi_overrun  output  1  sticky: SPI request lost.
- core_req  input  1  core access request; held with fields until granted.
- core_we  input  1  1=write, 0=read.
- core_addr  input  ADDR_WIDTH  core address.
- core_wdata  input  DATA_WIDTH  core write data.
- core_gnt  output  1  one-cycle pulse in the SRAM access cycle.
- core_rdata  output  DATA_WIDTH  equals sram_rdata.
- core_rdata_valid  output  1  one-cycle pulse, cycle after the granted read.
- sram_cs  output  1  SRAM select.
- sram_we  output  1  SRAM write enable.
- sram_addr  output  ADDR_WIDTH  SRAM address.
- sram_wdata  output  DATA_WIDTH  SRAM write data.
- sram_rdata  input  DATA_WIDTH  SRAM read data, 1-cycle latency after sram_cs.
- config_busy  output  1  SPI request pending or in flight.

Behaviour:
- Reset: FSM=IDLE; pending flags, read_sync edge register, spi_overrun, spi_rdata, all valid/gnt pulses and sram_cs/sram_we cleared; sram_addr/sram_wdata 0.
- Capture:
  - write_new captures spi_addr/spi_wdata into a write buffer and sets wr_pend.
  - A read_sync rising edge (read_sync=1, previous sample=0) captures spi_addr and sets rd_pend.
  - Captures are ignored when enable_configuration=0.
- Overrun: write_new while wr_pend=1, or a read edge while rd_pend=1, overwrites the buffer and sets spi_overrun (sticky until reset).
- FSM states: IDLE, SPI_WR, SPI_RD, SPI_RD_WAIT, CORE_ACC, CORE_RD_WAIT. All sram_* outputs decode from the registered state.
- IDLE priority: wr_pend → SPI_WR; else rd_pend → SPI_RD; else core_req → CORE_ACC; else stay.
- SPI_WR: sram_cs=1, sram_we=1, buffer addr/data; clear wr_pend; → IDLE.
- SPI_RD: sram_cs=1, sram_we=0; clear rd_pend; → SPI_RD_WAIT.
- SPI_RD_WAIT: register sram_rdata into spi_rdata; spi_rdata_valid=1 next cycle; → IDLE.
- CORE_ACC: sram_cs=1, sram_we=core_we, core fields driven; core_gnt=1; read → CORE_RD_WAIT, write → IDLE.
- CORE_RD_WAIT: core_rdata_valid=1; → IDLE.
- Latency:
  - write_new at cycle t → sram write at t+2.
  - read_sync edge at t → sram_cs at t+2, spi_rdata_valid at t+4.
  - core_req seen in IDLE at t → core_gnt at t+1.
- Simultaneous write_new and read edge: both captured; the write is served first, so the read returns the new data.
- Capture in the same cycle as the clear of that pending flag: set wins; no overrun.
- enable_configuration falls: the in-flight access completes; both pending flags clear without overrun.
- Back-to-back: minimum 2 cycles per access; core_req held continuously while SPI pending is starved (strict priority).
- config_busy = wr_pend | rd_pend | state in {SPI_WR, SPI_RD, SPI_RD_WAIT}.

Optional Feature:
- Macro: SPI_ARB_FAIRNESS_EN.
- Defined: a last_spi flag is set after each SPI access. In IDLE, if last_spi=1 and core_req=1, the core is served before any pending SPI request. last_spi clears after a core access.
- Undefined: strict SPI priority as above.

Test Plan:
- Reset with rst=0 for 2 cycles during SPI_RD → all outputs 0, FSM IDLE, rd_pend cleared.
- enable_configuration=1, write_new with addr 0x005, data 0xDEADBEEF at t → sram_cs=sram_we=1, addr 0x005, wdata 0xDEADBEEF at t+2; no core_gnt.
- Read edge on addr 0x005 after that write → spi_rdata=0xDEADBEEF, spi_rdata_valid single pulse at edge+4; read_sync held high → no second read.
- write_new (0x010 ← 0x12345678) and read edge (0x010) in the same cycle → write at t+2, read at t+4, spi_rdata=0x12345678.
- Core read 0x020 (preloaded 0xCAFEF00D) held; write_new in the same cycle → SPI write first, then core_gnt, core_rdata_valid with 0xCAFEF00D. With SPI_ARB_FAIRNESS_EN, core wins after a prior SPI access.
- Two write_new pulses 1 cycle apart while IDLE is busy with the core → spi_overrun=1; only the second data is written.

Source files
------------

// File: rtl/spi_config_memory_arbiter.sv
// spi_config_memory_arbiter: shares one single-port SRAM between SPI config accesses and the core.
// SPI_ARB_FAIRNESS_EN: after an SPI access, a waiting core request is served before further SPI work.
module spi_config_memory_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_configuration,
    input  logic                  write_new,
    input  logic                  read_sync,
    input  logic [ADDR_WIDTH-1:0] spi_addr,
    input  logic [DATA_WIDTH-1:0] spi_wdata,
    output logic [DATA_WIDTH-1:0] spi_rdata,
    output logic                  spi_rdata_valid,
    output logic                  spi_overrun,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_gnt,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_rdata_valid,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  config_busy
);
    typedef enum logic [2:0] {IDLE, SPI_WR, SPI_RD, SPI_RD_WAIT, CORE_ACC, CORE_RD_WAIT} state_t;
    state_t state, state_nxt;
    logic wr_pend, rd_pend, rs_q, last_spi;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic cap_wr, cap_rd, fair;
    assign cap_wr = enable_configuration & write_new;
    assign cap_rd = enable_configuration & read_sync & ~rs_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            wr_pend         <= 1'b0;
            rd_pend         <= 1'b0;
            rs_q            <= 1'b0;
            wr_addr         <= '0;
            wr_data         <= '0;
            rd_addr         <= '0;
            spi_rdata       <= '0;
            spi_rdata_valid <= 1'b0;
            spi_overrun     <= 1'b0;
        end else begin
            state           <= state_nxt;
            rs_q            <= read_sync;
            // a capture in the same cycle as the service clears the flag wins and is not an overrun
            wr_pend         <= cap_wr | (enable_configuration & wr_pend & (state != SPI_WR));
            rd_pend         <= cap_rd | (enable_configuration & rd_pend & (state != SPI_RD));
            spi_overrun     <= spi_overrun | (cap_wr & wr_pend & (state != SPI_WR))
                                           | (cap_rd & rd_pend & (state != SPI_RD));
            spi_rdata_valid <= state == SPI_RD_WAIT;
            if (cap_wr) begin
                wr_addr <= spi_addr;
                wr_data <= spi_wdata;
            end
            if (cap_rd) rd_addr <= spi_addr;
            if (state == SPI_RD_WAIT) spi_rdata <= sram_rdata;
        end
    end
`ifdef SPI_ARB_FAIRNESS_EN
    always_ff @(posedge clk) begin
        if (!rst) last_spi <= 1'b0;
        else last_spi <= (state == SPI_WR || state == SPI_RD) ? 1'b1 : (state == CORE_ACC) ? 1'b0 : last_spi;
    end
`else
    assign last_spi = 1'b0;
`endif
    assign fair = last_spi & core_req;
    always_comb begin
        state_nxt = state;
        case (state)
            // a core request arriving alongside an SPI capture waits for that SPI access
            IDLE:         state_nxt = fair ? CORE_ACC
                                    : (wr_pend & enable_configuration) ? SPI_WR
                                    : (rd_pend & enable_configuration) ? SPI_RD
                                    : (core_req & ~cap_wr & ~cap_rd) ? CORE_ACC : IDLE;
            SPI_WR:       state_nxt = IDLE;
            SPI_RD:       state_nxt = SPI_RD_WAIT;
            SPI_RD_WAIT:  state_nxt = IDLE;
            CORE_ACC:     state_nxt = core_we ? IDLE : CORE_RD_WAIT;
            CORE_RD_WAIT: state_nxt = IDLE;
            default:      state_nxt = IDLE;
        endcase
    end
    assign sram_cs          = (state == SPI_WR) | (state == SPI_RD) | (state == CORE_ACC);
    assign sram_we          = (state == SPI_WR) | ((state == CORE_ACC) & core_we);
    assign sram_addr        = (state == SPI_WR) ? wr_addr : (state == SPI_RD) ? rd_addr
                            : (state == CORE_ACC) ? core_addr : '0;
    assign sram_wdata       = (state == SPI_WR) ? wr_data : (state == CORE_ACC) ? core_wdata : '0;
    assign core_gnt         = state == CORE_ACC;
    assign core_rdata_valid = state == CORE_RD_WAIT;
    assign core_rdata       = sram_rdata;
    assign config_busy      = wr_pend | rd_pend | (state == SPI_WR) | (state == SPI_RD) | (state == SPI_RD_WAIT);
endmodule

// File: tb/tb_spi_config_memory_arbiter.sv
// tb_spi_config_memory_arbiter: vector table plus directed sequences against a behavioural SRAM.
module tb_spi_config_memory_arbiter;
    localparam int AW = 10, DW = 32;
    localparam logic Y = 1'b1, N = 1'b0;
    localparam logic [31:0] DE = 32'hDEADBEEF, C1 = 32'h12345678;
    logic clk, rst, en, wn, rs, creq, cwe;
    logic [AW-1:0] sa_in, caddr, sram_addr;
    logic [DW-1:0] sd_in, cwd, spi_rdata, core_rdata, sram_wdata, sram_rdata;
    logic spi_rdata_valid, spi_overrun, core_gnt, core_rdata_valid, sram_cs, sram_we, config_busy;
    logic [DW-1:0] mem [0:1023];
    logic bad_wr;
    int checks = 0, failures = 0;

    spi_config_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .enable_configuration(en), .write_new(wn), .read_sync(rs),
        .spi_addr(sa_in), .spi_wdata(sd_in), .spi_rdata(spi_rdata), .spi_rdata_valid(spi_rdata_valid),
        .spi_overrun(spi_overrun), .core_req(creq), .core_we(cwe), .core_addr(caddr),
        .core_wdata(cwd), .core_gnt(core_gnt), .core_rdata(core_rdata),
        .core_rdata_valid(core_rdata_valid), .sram_cs(sram_cs), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .config_busy(config_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            mem[10'h020] <= 32'hCAFEF00D;
            bad_wr <= 1'b0;
        end else if (sram_cs) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else sram_rdata <= mem[sram_addr];
            if (sram_we && sram_wdata == 32'hAAAA0001) bad_wr <= 1'b1;
        end
    end

    typedef struct {
        logic wn, rs;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic cs, we;
        logic [AW-1:0] sa;
        logic [DW-1:0] sd;
        logic gnt, rv, busy;
        logic [DW-1:0] rd;
    } vec_t;
    vec_t v [19];

    function automatic vec_t mk(input logic w, r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic cs, we, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                                input logic gnt, rv, busy, input logic [DW-1:0] rd);
        vec_t t;
        t.wn = w; t.rs = r; t.a = a; t.d = d; t.cs = cs; t.we = we; t.sa = sa; t.sd = sd;
        t.gnt = gnt; t.rv = rv; t.busy = busy; t.rd = rd;
        return t;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int wr_c, gnt_c, crv_c;
    logic [DW-1:0] crd;

    initial begin
        v[0]  = mk(Y, N, 10'h005, DE, N, N, 10'h000, 0,  N, N, N, 0);
        v[1]  = mk(N, N, 10'h005, DE, N, N, 10'h000, 0,  N, N, Y, 0);
        v[2]  = mk(N, N, 10'h005, DE, Y, Y, 10'h005, DE, N, N, Y, 0);
        v[3]  = mk(N, N, 10'h005, DE, N, N, 10'h000, 0,  N, N, N, 0);
        v[4]  = mk(N, Y, 10'h005, 0,  N, N, 10'h000, 0,  N, N, N, 0);
        v[5]  = mk(N, Y, 10'h005, 0,  N, N, 10'h000, 0,  N, N, Y, 0);
        v[6]  = mk(N, Y, 10'h005, 0,  Y, N, 10'h005, 0,  N, N, Y, 0);
        v[7]  = mk(N, Y, 10'h005, 0,  N, N, 10'h000, 0,  N, N, Y, 0);
        v[8]  = mk(N, Y, 10'h005, 0,  N, N, 10'h000, 0,  N, Y, N, DE);
        v[9]  = mk(N, Y, 10'h005, 0,  N, N, 10'h000, 0,  N, N, N, DE);
        v[10] = mk(N, N, 10'h005, 0,  N, N, 10'h000, 0,  N, N, N, DE);
        v[11] = mk(Y, Y, 10'h010, C1, N, N, 10'h000, 0,  N, N, N, DE);
        v[12] = mk(N, Y, 10'h010, C1, N, N, 10'h000, 0,  N, N, Y, DE);
        v[13] = mk(N, Y, 10'h010, C1, Y, Y, 10'h010, C1, N, N, Y, DE);
        v[14] = mk(N, Y, 10'h010, C1, N, N, 10'h000, 0,  N, N, Y, DE);
        v[15] = mk(N, Y, 10'h010, C1, Y, N, 10'h010, 0,  N, N, Y, DE);
        v[16] = mk(N, Y, 10'h010, C1, N, N, 10'h000, 0,  N, N, Y, DE);
        v[17] = mk(N, Y, 10'h010, C1, N, N, 10'h000, 0,  N, Y, N, C1);
        v[18] = mk(N, N, 10'h010, C1, N, N, 10'h000, 0,  N, N, N, C1);

        rst = 1'b0; en = 1'b1; wn = 1'b0; rs = 1'b0; sa_in = '0; sd_in = '0;
        creq = 1'b0; cwe = 1'b0; caddr = '0; cwd = '0;
        repeat (3) cyc();
        chk("rst_cs", sram_cs, 0);
        chk("rst_busy", config_busy, 0);
        chk("rst_ovr", spi_overrun, 0);
        chk("rst_rdata", spi_rdata, 0);
        rst = 1'b1;

        for (int i = 0; i < 19; i++) begin
            cyc();
            wn = v[i].wn; rs = v[i].rs; sa_in = v[i].a; sd_in = v[i].d;
            chk($sformatf("r%0d_cs", i), sram_cs, v[i].cs);
            chk($sformatf("r%0d_we", i), sram_we, v[i].we);
            chk($sformatf("r%0d_addr", i), sram_addr, v[i].sa);
            chk($sformatf("r%0d_wdata", i), sram_wdata, v[i].sd);
            chk($sformatf("r%0d_gnt", i), core_gnt, v[i].gnt);
            chk($sformatf("r%0d_rv", i), spi_rdata_valid, v[i].rv);
            chk($sformatf("r%0d_busy", i), config_busy, v[i].busy);
            chk($sformatf("r%0d_rdata", i), spi_rdata, v[i].rd);
        end

        // core read racing a fresh SPI write
        wr_c = -1; gnt_c = -1; crv_c = -1; crd = '0;
        for (int c = 0; c < 12; c++) begin
            cyc();
            if (sram_cs && sram_we && sram_addr == 10'h030 && wr_c < 0) wr_c = c;
            if (core_gnt && gnt_c < 0) gnt_c = c;
            if (core_rdata_valid && crv_c < 0) begin crv_c = c; crd = core_rdata; end
            wn = (c == 0); rs = 1'b0; sa_in = 10'h030; sd_in = 32'h11111111;
            creq = (c == 0) || (creq && !core_gnt); cwe = 1'b0; caddr = 10'h020;
        end
`ifdef SPI_ARB_FAIRNESS_EN
        chk("race_wr_cyc", wr_c, 4);
        chk("race_gnt_cyc", gnt_c, 1);
        chk("race_crv_cyc", crv_c, 2);
`else
        chk("race_wr_cyc", wr_c, 2);
        chk("race_gnt_cyc", gnt_c, 4);
        chk("race_crv_cyc", crv_c, 5);
`endif
        chk("race_core_rdata", crd, 32'hCAFEF00D);
        chk("race_mem30", mem[10'h030], 32'h11111111);
        creq = 1'b0;

        // capture during the service cycle: set wins, no overrun
        cyc(); wn = 1'b1; sa_in = 10'h050; sd_in = 32'hA1A1A1A1;
        cyc(); wn = 1'b0;
        cyc(); chk("setwin_wr1", sram_wdata, 32'hA1A1A1A1); chk("setwin_we1", sram_we, 1);
        wn = 1'b1; sd_in = 32'hA2A2A2A2;
        cyc(); wn = 1'b0; chk("setwin_busy", config_busy, 1);
        cyc(); chk("setwin_wr2", sram_wdata, 32'hA2A2A2A2); chk("setwin_addr2", sram_addr, 10'h050);
        cyc(); chk("setwin_ovr", spi_overrun, 0); chk("setwin_mem", mem[10'h050], 32'hA2A2A2A2);

        // enable falls during an SPI write with a read still pending
        cyc(); wn = 1'b1; rs = 1'b1; sa_in = 10'h060; sd_in = 32'hB1B1B1B1;
        cyc(); wn = 1'b0;
        cyc(); chk("endis_cs", sram_cs, 1); chk("endis_we", sram_we, 1); en = 1'b0;
        cyc(); chk("endis_cs_after", sram_cs, 0); chk("endis_busy", config_busy, 0);
        cyc(); wn = 1'b1; chk("endis_rv", spi_rdata_valid, 0);
        cyc(); wn = 1'b0; rs = 1'b0; chk("endis_ignored", config_busy, 0); chk("endis_cs2", sram_cs, 0);
        cyc(); en = 1'b1; chk("endis_ovr", spi_overrun, 0); chk("endis_rv2", spi_rdata_valid, 0);

        // two write pulses while the core holds the SRAM
        cyc(); creq = 1'b1; cwe = 1'b0; caddr = 10'h020;
        cyc(); chk("ovr_gnt", core_gnt, 1);
        creq = 1'b0; wn = 1'b1; sa_in = 10'h040; sd_in = 32'hAAAA0001;
        cyc(); wn = 1'b0; chk("ovr_crv", core_rdata_valid, 1); chk("ovr_crdata", core_rdata, 32'hCAFEF00D);
        cyc(); chk("ovr_busy", config_busy, 1); chk("ovr_pre", spi_overrun, 0);
        wn = 1'b1; sd_in = 32'hAAAA0002;
        cyc(); wn = 1'b0; chk("ovr_wdata", sram_wdata, 32'hAAAA0002); chk("ovr_addr", sram_addr, 10'h040);
        cyc(); chk("ovr_flag", spi_overrun, 1); chk("ovr_mem", mem[10'h040], 32'hAAAA0002);
        chk("ovr_nofirst", bad_wr, 0);

        // reset asserted for two cycles while a read is in SPI_RD
        cyc(); rs = 1'b1; sa_in = 10'h005;
        cyc();
        cyc(); chk("rstrd_cs", sram_cs, 1); chk("rstrd_we", sram_we, 0); rst = 1'b0; rs = 1'b0;
        cyc();
        chk("rstrd_cs0", sram_cs, 0); chk("rstrd_we0", sram_we, 0); chk("rstrd_addr0", sram_addr, 0);
        chk("rstrd_wdata0", sram_wdata, 0); chk("rstrd_gnt0", core_gnt, 0); chk("rstrd_rv0", spi_rdata_valid, 0);
        chk("rstrd_crv0", core_rdata_valid, 0); chk("rstrd_busy0", config_busy, 0);
        chk("rstrd_ovr0", spi_overrun, 0); chk("rstrd_rdata0", spi_rdata, 0);
        cyc(); rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            chk($sformatf("post_rst_busy%0d", c), config_busy, 0);
            chk($sformatf("post_rst_rv%0d", c), spi_rdata_valid, 0);
            chk($sformatf("post_rst_cs%0d", c), sram_cs, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
